cpu_datapath: RTL and testbench
===============================

# cpu_datapath

32-bit single-bus processor datapath: sixteen general registers, PC, IR, MAR, MDR, HI/LO, the ALU operand register Y and the 64-bit ALU result register Z, all joined by one shared 32-bit bus. A control unit or testbench drives one-hot-style out-enables to choose the bus source and in-enables to capture the bus on the clock edge. It sits between the control sequencer and memory: memory data enters through `Mdatain`, and register contents are exported for observation.

## Interface
- No parameters. Data width is fixed at 32 bits; Z is 64 bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous and active-high; clears every register to 0.
- `R0in`..`R15in`  in  1 each  load GPR Rn from the bus.
- `R0out`..`R15out`  in  1 each  drive Rn onto the bus.
- `HIin`, `Loin`, `PCin`, `IRin`, `MARin`, `Yin`  in  1 each  load the named register from the bus.
- `MDRin`  in  1  load MDR from the MDR input mux.
- `MDRread`  in  1  MDR mux select: 1 selects `Mdatain`, 0 selects the bus.
- `Zin`, `ZHIin`, `ZLOin`  in  1 each  load ALU result into all 64 bits of Z, into Z[63:32] only, or into Z[31:0] only.
- `HIout`, `Loout`, `PCout`, `MDRout`, `Yout`, `InPortout`, `Cout`  in  1 each  drive the named source onto the bus.
- `ZHIout`/`ZHighSelect`, `ZLOout`/`ZLowSelect`  in  1 each  the two signals in each pair are ORed; they drive Z[63:32] or Z[31:0] onto the bus.
- `IncPC`  in  1  PC <= PC + 1.
- `ALU_opcode`  in  5  ALU operation select.
- `Mdatain`  in  32  memory read data.
- `R0`..`R15`, `HI`, `LO`, `Y`  out  32 each  current register contents.
- `ZHI`, `ZLO`  out  32 each  Z[63:32] and Z[31:0].
- `Z_register`  out  64  full Z.

## Operation
- **Bus:** combinational mux. When several out-enables are active, the highest-priority source wins, in this order:
  - R0..R15
  - HI
  - LO
  - ZHI
  - ZLO
  - PC
  - MDR
  - InPort
  - C
  - Y
- **Idle bus:** with no out-enable active, the bus is 32'h0.
- **InPort:** no input-port register exists; `InPortout` drives 32'h0.
- **C constant:** `Cout` drives IR[18:0] sign-extended to 32 bits.
- **ALU operands:** A = Y, B = bus. The 64-bit result is combinational; the unused upper half is 0 unless stated otherwise.
- **Opcodes:**
  - 00000, 00001, 00010, 00011, 01100: A+B
  - 00100: A−B
  - 00101, 01101: A&B
  - 00110, 01110: A|B
  - 00111: logical shift right A by B[4:0]
  - 01000: arithmetic shift right A by B[4:0]
  - 01001: shift left A by B[4:0]
  - 01010: rotate right A by B[4:0]
  - 01011: rotate left A by B[4:0]
  - 01111: signed 64-bit product A×B
  - 10000: signed divide A/B; Z[31:0] = quotient (truncated toward zero), Z[63:32] = remainder (same sign as A)
  - 10001: −B
  - 10010: ~B
  - all other codes: result 0
- **Divide by zero:** quotient = 32'hFFFFFFFF, remainder = A.
- **Add/sub overflow:** wraps modulo 2^32; no flags are produced.
- **R0:** an ordinary register with no hardwired zero.

## Timing
- All loads are captured on the rising edge of `clk` from the values present just before the edge; register outputs update after that edge.
- **Reset:** `clr` high at an edge sets every register to 0 and overrides every in-enable. All outputs read 0 after the reset edge.
- **PC priority:** `clr` > `IncPC` > `PCin`.
- **Read-and-load in one cycle:** a register that is both bus source and destination in the same cycle loads its own old value.
- **ALU path:** Y must be loaded at least one edge before the ALU op. The operation then completes in one cycle: result captured in Z at the Zin/ZHIin/ZLOin edge.
- **Moving Z to HI/LO:** takes one further cycle each (ZLOout + Loin, then ZHIout + HIin).
- **Z loads:** `Zin` together with `ZHIin` or `ZLOin` behaves exactly as `Zin`.
- **MDR load:** memory-to-register transfers take two cycles:
  - cycle 1: `MDRread` + `MDRin` loads `Mdatain` into MDR
  - cycle 2: `MDRout` + `Rnin` moves MDR into Rn

## Test plan
- **Reset:** preload R3 = 5, then `clr` for one edge -> R0..R15, HI, LO, Y, Z all read 0.
- **Divide:** Mdatain = 0x00000F0F to R6 and 0x0000FF0F to R7 via MDR; R6out+Yin; opcode 10000 with R7out+ZLOin+ZHIin -> ZLO = 0, ZHI = 0x00000F0F. Then ZLOout+Loin gives LO = 0, and ZHIout+HIin gives HI = 0x00000F0F.
- **Signed divide:** Y = −7, B = 2 -> ZLO = −3 (0xFFFFFFFD), ZHI = −1. With B = 0 -> ZLO = 0xFFFFFFFF, ZHI = −7.
- **Multiply:** Y = 0xFFFFFFFE, B = 3, opcode 01111 -> Z_register = 0xFFFFFFFF_FFFFFFFA.
- **Shift/rotate:** Y = 0x80000001, B = 1: opcode 01011 -> ZLO = 0x00000003; opcode 01000 -> ZLO = 0xC0000000.
- **Bus/MDR/PC:** `MDRread` + `R1in` with no out-enable -> R1 = 0. With PC = 7, `IncPC` and `PCin` together (bus = 0x20) -> PC = 8.

Source files
------------

// File: rtl/cpu_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_datapath_if
//  Description : Control/observation bundle between the control sequencer
//                (master) and the single-bus 32-bit datapath (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_datapath_if;
  // GPR enables, bit n addresses Rn
  logic [15:0]       Rin;
  logic [15:0]       Rout;
  // special-register load enables
  logic              HIin, Loin, PCin, IRin, MARin, Yin, MDRin, MDRread;
  logic              Zin, ZHIin, ZLOin;
  // bus source enables
  logic              HIout, Loout, PCout, MDRout, Yout, InPortout, Cout;
  logic              ZHIout, ZHighSelect, ZLOout, ZLowSelect;
  logic              IncPC;
  logic [4:0]        ALU_opcode;
  logic [31:0]       Mdatain;
  // register contents exported for observation
  logic [15:0][31:0] R;
  logic [31:0]       HI, LO, Y, ZHI, ZLO;
  logic [31:0]       PC, IR, MAR, MDR;
  logic [63:0]       Z_register;

  modport master (
    output Rin, Rout, HIin, Loin, PCin, IRin, MARin, Yin, MDRin, MDRread,
           Zin, ZHIin, ZLOin, HIout, Loout, PCout, MDRout, Yout, InPortout,
           Cout, ZHIout, ZHighSelect, ZLOout, ZLowSelect, IncPC, ALU_opcode,
           Mdatain,
    input  R, HI, LO, Y, ZHI, ZLO, PC, IR, MAR, MDR, Z_register
  );

  modport slave (
    input  Rin, Rout, HIin, Loin, PCin, IRin, MARin, Yin, MDRin, MDRread,
           Zin, ZHIin, ZLOin, HIout, Loout, PCout, MDRout, Yout, InPortout,
           Cout, ZHIout, ZHighSelect, ZLOout, ZLowSelect, IncPC, ALU_opcode,
           Mdatain,
    output R, HI, LO, Y, ZHI, ZLO, PC, IR, MAR, MDR, Z_register
  );
endinterface
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_datapath
//  Description : 32-bit single-bus processor datapath. Sixteen GPRs, PC, IR,
//                MAR, MDR, HI/LO, ALU operand Y and 64-bit result Z share one
//                combinational priority bus. ALU takes A = Y, B = bus.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_datapath (
  input  logic          clk,
  input  logic          clr,
  cpu_datapath_if.slave dp
);

  // ALU operation codes
  localparam logic [4:0] OP_ADD0 = 5'b00000;
  localparam logic [4:0] OP_ADD1 = 5'b00001;
  localparam logic [4:0] OP_ADD2 = 5'b00010;
  localparam logic [4:0] OP_ADD3 = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND0 = 5'b00101;
  localparam logic [4:0] OP_OR0  = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADD4 = 5'b01100;
  localparam logic [4:0] OP_AND1 = 5'b01101;
  localparam logic [4:0] OP_OR1  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // architectural state
  logic [15:0][31:0] gpr_q, gpr_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d, y_q, y_d;
  logic [31:0]       pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [63:0]       z_q, z_d;

  // bus and ALU nets
  logic [31:0] bus;
  logic [31:0] c_sext;
  logic        zhi_sel, zlo_sel;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  sh;
  logic [5:0]  sh_inv;
  logic [63:0] prod;
  logic [31:0] divisor, quot, rem;
  logic [63:0] alu_res;

  assign c_sext  = {{13{ir_q[18]}}, ir_q[18:0]};
  assign zhi_sel = dp.ZHIout | dp.ZHighSelect;
  assign zlo_sel = dp.ZLOout | dp.ZLowSelect;

  // Bus source mux: assignments run lowest to highest priority so the last
  // active source wins; R0 ends up the strongest source.
  always_comb begin
    bus = 32'h0;
    if (dp.Yout)      bus = y_q;
    if (dp.Cout)      bus = c_sext;
    if (dp.InPortout) bus = 32'h0;
    if (dp.MDRout)    bus = mdr_q;
    if (dp.PCout)     bus = pc_q;
    if (zlo_sel)      bus = z_q[31:0];
    if (zhi_sel)      bus = z_q[63:32];
    if (dp.Loout)     bus = lo_q;
    if (dp.HIout)     bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (dp.Rout[i]) bus = gpr_q[i];
    end
  end

  assign alu_a   = y_q;
  assign alu_b   = bus;
  assign sh      = alu_b[4:0];
  assign sh_inv  = 6'd32 - {1'b0, sh};
  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign prod    = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
  // Divisor of zero is replaced so the divider never sees it; the result is
  // overridden below anyway.
  assign divisor = (alu_b == 32'h0) ? 32'd1 : alu_b;
  assign quot    = $signed(alu_a) / $signed(divisor);
  assign rem     = $signed(alu_a) % $signed(divisor);

  // ALU result, combinational; upper half is zero except MUL and DIV.
  always_comb begin
    alu_res = 64'h0;
    case (dp.ALU_opcode)
      OP_ADD0, OP_ADD1, OP_ADD2, OP_ADD3, OP_ADD4:
                alu_res = {32'h0, alu_a + alu_b};
      OP_SUB:   alu_res = {32'h0, alu_a - alu_b};
      OP_AND0, OP_AND1:
                alu_res = {32'h0, alu_a & alu_b};
      OP_OR0, OP_OR1:
                alu_res = {32'h0, alu_a | alu_b};
      OP_SHR:   alu_res = {32'h0, alu_a >> sh};
      OP_SHRA:  alu_res = {32'h0, $signed(alu_a) >>> sh};
      OP_SHL:   alu_res = {32'h0, alu_a << sh};
      OP_ROR:   alu_res = {32'h0, (alu_a >> sh) | (alu_a << sh_inv)};
      OP_ROL:   alu_res = {32'h0, (alu_a << sh) | (alu_a >> sh_inv)};
      OP_MUL:   alu_res = prod;
      OP_DIV: begin
        if (alu_b == 32'h0) alu_res = {alu_a, 32'hFFFF_FFFF};
        else                alu_res = {rem, quot};
      end
      OP_NEG:   alu_res = {32'h0, 32'h0 - alu_b};
      OP_NOT:   alu_res = {32'h0, ~alu_b};
      default:  alu_res = 64'h0;
    endcase
  end

  // Next-state for every register; reset is applied in the state register.
  always_comb begin
    gpr_d = gpr_q;
    for (int i = 0; i < 16; i++) begin
      if (dp.Rin[i]) gpr_d[i] = bus;
    end
    hi_d  = dp.HIin  ? bus : hi_q;
    lo_d  = dp.Loin  ? bus : lo_q;
    y_d   = dp.Yin   ? bus : y_q;
    ir_d  = dp.IRin  ? bus : ir_q;
    mar_d = dp.MARin ? bus : mar_q;
    mdr_d = dp.MDRin ? (dp.MDRread ? dp.Mdatain : bus) : mdr_q;

    // increment takes precedence over a bus load
    pc_d = pc_q;
    if (dp.IncPC)     pc_d = pc_q + 32'd1;
    else if (dp.PCin) pc_d = bus;

    // full load dominates the half loads
    z_d = z_q;
    if (dp.Zin) begin
      z_d = alu_res;
    end else begin
      if (dp.ZHIin) z_d[63:32] = alu_res[63:32];
      if (dp.ZLOin) z_d[31:0]  = alu_res[31:0];
    end
  end

  // State register with synchronous clear overriding all enables.
  always_ff @(posedge clk) begin
    if (clr) begin
      gpr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      z_q   <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      z_q   <= z_d;
    end
  end

  assign dp.R          = gpr_q;
  assign dp.HI         = hi_q;
  assign dp.LO         = lo_q;
  assign dp.Y          = y_q;
  assign dp.PC         = pc_q;
  assign dp.IR         = ir_q;
  assign dp.MAR        = mar_q;
  assign dp.MDR        = mdr_q;
  assign dp.ZHI        = z_q[63:32];
  assign dp.ZLO        = z_q[31:0];
  assign dp.Z_register = z_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_datapath
//  Description : Directed self-checking bench for cpu_datapath with an
//                expected-value queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_datapath;

  logic clk = 1'b0;
  logic clr = 1'b0;

  cpu_datapath_if dif ();

  cpu_datapath u_dut (
    .clk (clk),
    .clr (clr),
    .dp  (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    dif.Rin = '0; dif.Rout = '0;
    dif.HIin = 0; dif.Loin = 0; dif.PCin = 0; dif.IRin = 0; dif.MARin = 0;
    dif.Yin = 0; dif.MDRin = 0; dif.MDRread = 0;
    dif.Zin = 0; dif.ZHIin = 0; dif.ZLOin = 0;
    dif.HIout = 0; dif.Loout = 0; dif.PCout = 0; dif.MDRout = 0; dif.Yout = 0;
    dif.InPortout = 0; dif.Cout = 0;
    dif.ZHIout = 0; dif.ZHighSelect = 0; dif.ZLOout = 0; dif.ZLowSelect = 0;
    dif.IncPC = 0; dif.ALU_opcode = '0; dif.Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    clr = 1'b0;
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h expected <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // memory word -> MDR -> Rn
  task automatic mem_to_reg(input int n, input logic [31:0] v);
    dif.MDRread = 1; dif.MDRin = 1; dif.Mdatain = v;
    tick();
    dif.MDRout = 1; dif.Rin[n] = 1;
    tick();
  endtask

  // Y <- Ra, then Z <- Y op Rb
  task automatic run_alu(input int ra, input int rb, input logic [4:0] op,
                         input bit halves);
    dif.Rout[ra] = 1; dif.Yin = 1;
    tick();
    dif.Rout[rb] = 1; dif.ALU_opcode = op;
    if (halves) begin dif.ZHIin = 1; dif.ZLOin = 1; end
    else        dif.Zin = 1;
    tick();
  endtask

  // Reference ALU for the simple operations; rotates computed bit by bit.
  function automatic logic [63:0] model(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    int          s;
    s = int'(b[4:0]);
    r = 32'h0;
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100: r = a + b;
      5'b00100: r = a + ~b + 32'd1;
      5'b00101, 5'b01101: r = a & b;
      5'b00110, 5'b01110: r = a | b;
      5'b00111: r = a >> s;
      5'b01001: r = a << s;
      5'b01010: for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
      5'b01011: for (int i = 0; i < 32; i++) r[(i + s) % 32] = a[i];
      5'b10001: r = ~b + 32'd1;
      5'b10010: r = ~b;
      default:  r = 32'h0;
    endcase
    return {32'h0, r};
  endfunction

  logic [4:0]  t_op [10] = '{5'b00000, 5'b01100, 5'b00100, 5'b00101, 5'b01110,
                             5'b00111, 5'b01001, 5'b01010, 5'b10001, 5'b11111};
  logic [31:0] t_a  [10] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0003,
                             32'hF0F0_F0F0, 32'h0F00_0000, 32'h8000_0000,
                             32'h0000_0001, 32'h0000_00F1, 32'h0000_0000,
                             32'hDEAD_BEEF};
  logic [31:0] t_b  [10] = '{32'h0000_0001, 32'h1111_1111, 32'h0000_0005,
                             32'h3C3C_3C3C, 32'h0000_00F0, 32'h0000_001F,
                             32'h0000_0024, 32'h0000_0004, 32'h0000_0005,
                             32'h0000_0001};

  initial begin
    idle();
    clr = 1'b1;
    tick();

    // reset: preload R3, then clear everything
    mem_to_reg(3, 32'd5);
    sb_push("preload_r3", 64'd5);
    sb_check({32'h0, dif.R[3]});
    clr = 1'b1; dif.Rin = '1; dif.IncPC = 1; dif.Zin = 1;
    for (int i = 0; i < 16; i++) sb_push($sformatf("rst_r%0d", i), 64'h0);
    sb_push("rst_hi", 64'h0); sb_push("rst_lo", 64'h0);
    sb_push("rst_y", 64'h0);  sb_push("rst_z", 64'h0);
    sb_push("rst_pc", 64'h0);
    tick();
    for (int i = 0; i < 16; i++) sb_check({32'h0, dif.R[i]});
    sb_check({32'h0, dif.HI}); sb_check({32'h0, dif.LO});
    sb_check({32'h0, dif.Y});  sb_check(dif.Z_register);
    sb_check({32'h0, dif.PC});

    // divide via half loads, then move Z halves to LO/HI
    mem_to_reg(6, 32'h0000_0F0F);
    mem_to_reg(7, 32'h0000_FF0F);
    sb_push("div_zlo", 64'h0); sb_push("div_zhi", 64'h0F0F);
    run_alu(6, 7, 5'b10000, 1'b1);
    sb_check({32'h0, dif.ZLO}); sb_check({32'h0, dif.ZHI});
    dif.ZLOout = 1; dif.Loin = 1;
    sb_push("div_lo", 64'h0);
    tick();
    sb_check({32'h0, dif.LO});
    dif.ZHIout = 1; dif.HIin = 1;
    sb_push("div_hi", 64'h0F0F);
    tick();
    sb_check({32'h0, dif.HI});

    // signed divide and divide by zero
    mem_to_reg(1, 32'hFFFF_FFF9);
    mem_to_reg(2, 32'd2);
    sb_push("sdiv", 64'hFFFF_FFFF_FFFF_FFFD);
    run_alu(1, 2, 5'b10000, 1'b0);
    sb_check(dif.Z_register);
    mem_to_reg(2, 32'd0);
    sb_push("div0", 64'hFFFF_FFF9_FFFF_FFFF);
    run_alu(1, 2, 5'b10000, 1'b0);
    sb_check(dif.Z_register);

    // signed multiply
    mem_to_reg(1, 32'hFFFF_FFFE);
    mem_to_reg(2, 32'd3);
    sb_push("mul", 64'hFFFF_FFFF_FFFF_FFFA);
    run_alu(1, 2, 5'b01111, 1'b0);
    sb_check(dif.Z_register);

    // rotate left and arithmetic shift right
    mem_to_reg(1, 32'h8000_0001);
    mem_to_reg(2, 32'd1);
    sb_push("rol", 64'h3);
    run_alu(1, 2, 5'b01011, 1'b0);
    sb_check(dif.Z_register);
    sb_push("asr", 64'hC000_0000);
    run_alu(1, 2, 5'b01000, 1'b0);
    sb_check(dif.Z_register);

    // table of simple ALU ops against the reference model
    for (int k = 0; k < 10; k++) begin
      mem_to_reg(1, t_a[k]);
      mem_to_reg(2, t_b[k]);
      sb_push($sformatf("alu_op%b", t_op[k]), model(t_op[k], t_a[k], t_b[k]));
      run_alu(1, 2, t_op[k], 1'b0);
      sb_check(dif.Z_register);
    end

    // idle bus with MDRread only: R1 loads zero
    dif.MDRread = 1; dif.Rin[1] = 1;
    sb_push("idle_bus", 64'h0);
    tick();
    sb_check({32'h0, dif.R[1]});

    // PC: load 7, then IncPC beats PCin
    mem_to_reg(4, 32'd7);
    mem_to_reg(5, 32'h20);
    dif.Rout[4] = 1; dif.PCin = 1;
    sb_push("pc_load", 64'd7);
    tick();
    sb_check({32'h0, dif.PC});
    dif.Rout[5] = 1; dif.PCin = 1; dif.IncPC = 1;
    sb_push("pc_inc", 64'd8);
    tick();
    sb_check({32'h0, dif.PC});

    // bus priority: lower GPR beats higher GPR, HI and Y; HI beats PC
    mem_to_reg(2, 32'hAAAA_0002);
    mem_to_reg(11, 32'hBBBB_000B);
    dif.Rout[2] = 1; dif.Rout[11] = 1; dif.HIout = 1; dif.Yout = 1;
    dif.Rin[9] = 1;
    sb_push("prio_gpr", 64'hAAAA_0002);
    tick();
    sb_check({32'h0, dif.R[9]});
    dif.HIout = 1; dif.PCout = 1; dif.Rin[12] = 1;
    sb_push("prio_hi_pc", 64'h0F0F);
    tick();
    sb_check({32'h0, dif.R[12]});

    // same register as source and destination keeps its value
    dif.Rout[11] = 1; dif.Rin[11] = 1;
    sb_push("self_load", 64'hBBBB_000B);
    tick();
    sb_check({32'h0, dif.R[11]});

    // C constant: IR[18:0] sign-extended
    dif.MDRread = 1; dif.MDRin = 1; dif.Mdatain = 32'h7FC4_0005;
    tick();
    dif.MDRout = 1; dif.IRin = 1;
    tick();
    dif.Cout = 1; dif.Rin[10] = 1;
    sb_push("cout", 64'hFFFC_0005);
    tick();
    sb_check({32'h0, dif.R[10]});

    // InPort drives zero even over a lower-priority Y
    dif.InPortout = 1; dif.Yout = 1; dif.Rin[13] = 1;
    sb_push("inport", 64'h0);
    tick();
    sb_check({32'h0, dif.R[13]});

    // Zin with ZLOin loads the full 64 bits
    mem_to_reg(1, 32'hFFFF_FFFE);
    mem_to_reg(2, 32'd3);
    dif.Rout[1] = 1; dif.Yin = 1;
    tick();
    dif.Rout[2] = 1; dif.ALU_opcode = 5'b01111; dif.Zin = 1; dif.ZLOin = 1;
    sb_push("zin_full", 64'hFFFF_FFFF_FFFF_FFFA);
    tick();
    sb_check(dif.Z_register);

    // ZLOin alone leaves the upper half intact
    mem_to_reg(2, 32'd1);
    dif.Rout[1] = 1; dif.Yin = 1;
    tick();
    dif.Rout[2] = 1; dif.ALU_opcode = 5'b00000; dif.ZLOin = 1;
    sb_push("zlo_only", 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    sb_check(dif.Z_register);

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
